watch_disp_scan: RTL
====================

// Module: watch_disp_scan
// PURPOSE
//  Reader side of the stopwatch display buffer: consumes the packed BCD dispbuf from the watch counter
//  and drives a multiplexed common-anode/cathode 7-segment array, one digit per scan slot.
//  Adds frame-coherent snapshot, anti-ghost blanking, leading-zero suppression, decimal points and blink.
//  Sits between watch_cnt and the board pins; all outputs registered.
// PARAMETERS
//  NUM_DIGITS      6    digits scanned; dispbuf width = 4*NUM_DIGITS
//  SCAN_DIV        2    clk_1Khz cycles per digit slot (>=1)
//  BLANK_CYC       1    leading cycles of each slot with all digits off; must be < SCAN_DIV
//  BLINK_HALF      500  cycles per blink half-period (500 -> 1 Hz at 1 kHz)
//  SEG_ACTIVE_LOW  1    1: seg lit = 0
//  DIG_ACTIVE_LOW  1    1: dig_sel enabled = 0
// PORTS
//  clk_1Khz     in   1             1 kHz system clock
//  rst          in   1             synchronous active-high reset
//  dispbuf      in   4*NUM_DIGITS  BCD digits; digit i = dispbuf[4i+3:4i], digit 0 rightmost
//  dp_mask      in   NUM_DIGITS    1 = light decimal point of digit i
//  lz_en        in   1             1 = suppress leading zeros
//  blink_mask   in   NUM_DIGITS    1 = digit i blinks
//  seg          out  8             {dp,g,f,e,d,c,b,a}
//  dig_sel      out  NUM_DIGITS    one-hot digit enable (polarity per DIG_ACTIVE_LOW)
//  frame_start  out  1             1-cycle pulse with first output cycle of digit 0
// BEHAVIOUR
//  - Reset (sync): div_cnt=0, idx=0, snapshot=0, blink_cnt=0, blink_ph=0; seg=all-off, dig_sel=all-off,
//    frame_start=0 on the edge where rst is sampled high. Reset mid-frame aborts the frame immediately.
//  - div_cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and idx advances, NUM_DIGITS-1 wraps to 0.
//  - Snapshot: dispbuf, dp_mask, blink_mask loaded into snapshot on the edge where div_cnt=SCAN_DIV-1
//    and idx=NUM_DIGITS-1 (entering digit 0). A whole frame shows one coherent value; input changes
//    mid-frame are not visible until the next frame. lz_en is sampled directly.
//  - Latency: outputs for counter state (idx,div_cnt) appear one cycle later (single output register).
//  - Slot output: div_cnt<BLANK_CYC -> dig_sel all-off, seg all-off. Otherwise dig_sel enables only idx.
//  - Segment code (active-high, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F;
//    nibble A..F -> 40 (dash). seg[7] = snapshot dp_mask[idx].
//  - Leading-zero: with lz_en=1, digit i>=1 is suppressed when all snapshot digits j>=i are 0; digit 0
//    is never suppressed. Suppressed digit: seg[6:0] off, dp still honoured, dig_sel still asserted.
//  - Blink: blink_cnt counts 0..BLINK_HALF-1; blink_ph toggles on wrap. blink_ph=1 and blink_mask[idx]=1
//    -> seg all-off (incl. dp), dig_sel still asserted. blink_ph=0 -> normal.
//  - Priority: blank slot > blink > leading-zero > normal decode.
//  - frame_start=1 in the output cycle for (idx=0, div_cnt=0), else 0; period NUM_DIGITS*SCAN_DIV.
//  - Polarity: SEG_ACTIVE_LOW / DIG_ACTIVE_LOW invert final values; "all-off" = inactive level.
// STRUCTURE
//  - Shared package watch_pkg: SEG_0..SEG_9, SEG_DASH, SEG_OFF constants; BCD digit typedef.
//  - Sub-module bcd_to_seg7: combinational 4-bit BCD -> 7-bit active-high segments (incl. dash).
//  - Top holds div/idx/blink counters, snapshot regs, leading-zero mask, output register.
// TESTING  (defaults, active-low; BLINK_HALF=4 where noted)
//  1 rst high 3 cycles -> seg=8'hFF, dig_sel=6'h3F, frame_start=0; release -> cycle1 blank,
//    cycle2 dig_sel=6'h3E, seg=8'hC0 ("0"), frame_start=1 on cycle1.
//  2 dispbuf=24'h012345, dp_mask=6'b000100 -> next frame: digit0 seg=8'h92 ("5"),
//    digit2 seg=8'h30 ("3"+dp), digit5 seg=8'hC0.
//  3 change dispbuf 24'h111111->24'h999999 during digit 2 slot -> digits 3..5 still show "1"
//    (seg=8'hF9) this frame; "9" (seg=8'h90) from next frame.
//  4 lz_en=1, dispbuf=24'h000705 -> digits 5,4,3 seg=8'hFF with dig_sel asserted; digit2 8'hF8,
//    digit1 8'hC0, digit0 8'h92. dispbuf=0 -> only digit0 lit "0".
//  5 dispbuf=24'h00000C -> digit0 seg=8'hBF (dash).
//  6 BLINK_HALF=4, blink_mask=6'b110000 -> digits 5,4 seg=8'hFF in alternate 4-cycle windows,
//    digits 3..0 unaffected; rst mid-frame -> idx restarts at 0, blink_ph=0.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared definitions for the stopwatch display path: BCD digit type and
// active-high 7-segment codes in {g,f,e,d,c,b,a} order.
package watch_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Apply pin polarity to an active-high {dp,g..a} byte.
  function automatic logic [7:0] seg_to_pin(input logic [7:0] seg_hi, input bit act_low);
    return act_low ? ~seg_hi : seg_hi;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high segments.
// Non-decimal nibbles (A..F) show a dash so corrupted counter values are
// visible on the display instead of rendering as odd glyphs.
module bcd_to_seg7
  import watch_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  // Decode one digit; every code outside 0..9 maps to the dash.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/watch_disp_scan.sv
// Multiplexed 7-segment scanner for the stopwatch display buffer.
// A frame visits digits 0..NUM_DIGITS-1, SCAN_DIV cycles each. The first
// BLANK_CYC cycles of every slot drive everything off so the previous
// digit's segments do not ghost onto the newly selected digit.
// The display value is captured once per frame (entering digit 0), so a
// frame never mixes old and new counter values. Outputs are registered:
// the pins reflect the counter state of the previous cycle.
module watch_disp_scan
  import watch_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 2,
  parameter int BLANK_CYC      = 1,
  parameter int BLINK_HALF     = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_1Khz,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] dispbuf,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W   = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_BLANK  = DIV_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  // Inactive pin levels ("all-off") for each output group.
  localparam logic [7:0]            SEG_PIN_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_PIN_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                                 : {NUM_DIGITS{1'b0}};

  // Scan position and blink timebase.
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;

  // Frame-coherent copy of the display inputs.
  bcd_t [NUM_DIGITS-1:0] snap_dig_q;
  logic [NUM_DIGITS-1:0] snap_dp_q;
  logic [NUM_DIGITS-1:0] snap_blink_q;

  // Registered pin values.
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  frame_start_q, frame_start_d;

  // Derived per-cycle signals.
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  bcd_t                  cur_dig;
  logic [6:0]            cur_seg7;
  logic [7:0]            seg_hi;
  logic [NUM_DIGITS-1:0] dig_hi;

  // Last cycle of the last digit: the next cycle starts a new frame.
  assign frame_end = (div_q == DIV_LAST) && (idx_q == IDX_LAST);

  // Slot divider and digit index: div wraps every SCAN_DIV cycles, idx steps on the wrap.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Blink timebase: phase flips every BLINK_HALF cycles.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    blink_ph_d  = blink_ph_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  // Counter registers; reset restarts the frame at digit 0, blink phase 0.
  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      div_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  // Capture the display inputs only when entering digit 0.
  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      snap_blink_q <= '0;
    end else if (frame_end) begin
      snap_dig_q   <= dispbuf;
      snap_dp_q    <= dp_mask;
      snap_blink_q <= blink_mask;
    end
  end

  // Leading-zero mask: digit i (i>=1) is a leading zero when it and every
  // more significant snapshot digit are zero. Digit 0 always shows.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (snap_dig_q[i] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end

  assign cur_dig = snap_dig_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_dig),
    .seg_o (cur_seg7)
  );

  // Slot output, priority: blank window > blink > leading zero > decode.
  always_comb begin
    seg_hi = {1'b0, SEG_OFF};
    dig_hi = '0;
    if (div_q >= DIV_BLANK) begin
      dig_hi = NUM_DIGITS'(1) << idx_q;
      if (blink_ph_q && snap_blink_q[idx_q]) begin
        seg_hi = {1'b0, SEG_OFF};
      end else if (lz_en && lz_mask[idx_q]) begin
        seg_hi = {snap_dp_q[idx_q], SEG_OFF};
      end else begin
        seg_hi = {snap_dp_q[idx_q], cur_seg7};
      end
    end
    seg_d         = seg_to_pin(seg_hi, SEG_ACTIVE_LOW);
    dig_d         = DIG_ACTIVE_LOW ? ~dig_hi : dig_hi;
    frame_start_d = (idx_q == '0) && (div_q == '0);
  end

  // Output register; pins go inactive on the reset edge.
  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      seg_q         <= SEG_PIN_OFF;
      dig_q         <= DIG_PIN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dig_sel     = dig_q;
  assign frame_start = frame_start_q;

endmodule
